ldpc_cw_serializer: RTL and testbench
=====================================

Name: ldpc_cw_serializer

Overview:
- Downstream neighbour of qc_encoder. Captures each 162-bit qc_encoder output word on its valid strobe into a 2-entry ping-pong buffer.
- Emits each buffered word as 27-bit slices on an AXI-Stream-style valid/ready master port.
- Marks codeword boundaries with m_tlast and counts completed codewords.
- qc_encoder has no backpressure input, so buffer overrun is detected and flagged rather than stalled.

Parameters:
- IN_W, 162, input word width; must be an integer multiple of OUT_W.
- OUT_W, 27, output slice width.
- WORDS_PER_CW, 19, input words per codeword.
- CNT_W, 16, width of the codeword counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data holds a word to capture this cycle.
- in_data  input  IN_W  encoder output word.
- m_tvalid  output  1  m_tdata/m_tlast valid.
- m_tready  input  1  downstream accepts the slice this cycle.
- m_tdata  output  OUT_W  current slice.
- m_tlast  output  1  last slice of the codeword.
- overflow  output  1  sticky flag: an input word was dropped.
- cw_count  output  CNT_W  number of completed codewords.

Behaviour:
- Constants:
  - SLICES = IN_W/OUT_W (default 6).
  - Handshake ("pop") = m_tvalid && m_tready.
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr, occupancy = 0; slice_idx, word_idx = 0.
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0, overflow = 0, cw_count = 0.
  - Buffer contents need no reset.
- Reset mid-operation: all partial codeword state is discarded. The first word captured after reset release is word 0 of a new codeword.
- Write side:
  - in_valid && (occupancy<2 || word_done_pop) → store in_data at buf[wr_ptr], toggle wr_ptr.
  - word_done_pop = pop && slice_idx==SLICES-1.
  - in_valid && occupancy==2 && !word_done_pop → word dropped, overflow <= 1. overflow stays set until reset. Pointers and occupancy are unchanged.
- Occupancy update:
  - +1 on write only.
  - -1 on word_done_pop only.
  - Unchanged when both occur in the same cycle.
- Read FSM states:
  - IDLE: occupancy==0, m_tvalid=0.
  - SEND: occupancy>0, m_tvalid=1.
- Read FSM transitions:
  - IDLE→SEND the cycle after a write. Latency: in_valid at edge N → m_tvalid=1 after edge N+1.
  - SEND→IDLE after word_done_pop when occupancy becomes 0.
  - SEND→SEND otherwise, with no bubble between consecutive buffered words.
- Output data:
  - Slice order is LSB first: m_tdata = buf[rd_ptr][slice_idx*OUT_W +: OUT_W].
  - m_tdata and m_tlast are registered or directly mux-derived from registered state. They must stay stable while m_tvalid && !m_tready.
- Indices:
  - slice_idx increments on pop and wraps SLICES-1→0; at the wrap, rd_ptr toggles.
  - word_idx increments on word_done_pop and wraps WORDS_PER_CW-1→0.
- m_tlast = m_tvalid && slice_idx==SLICES-1 && word_idx==WORDS_PER_CW-1.
- cw_count increments on pop && m_tlast. It wraps modulo 2^CNT_W.
- Dropped words do not advance word_idx. Codeword alignment is lost after an overflow, and overflow signals that to software.
- m_tready is ignored while m_tvalid=0.

Decomposition:
- Shared package ldpc_pkg holds:
  - localparams CW_IN_W=162, CW_SLICE_W=27, CW_WORDS=19, CW_SLICES=CW_IN_W/CW_SLICE_W.
  - typedef cw_word_t (logic [161:0]) and cw_slice_t (logic [26:0]), for reuse by qc_encoder and its bench.
- One natural sub-module: cw_pingpong_buf.
  - Contains the 2-entry storage, pointers and occupancy.
  - Exposes wr_en/full/rd_word/pop_word.
- The slicing FSM, indices, tlast and counter stay in the top module.

Test Plan:
- Single word, m_tready=1 constant: in_data = {6 slices 0x1,0x2,...,0x6 LSB first} → m_tvalid high 6 consecutive cycles starting 1 cycle after in_valid; m_tdata 1,2,3,4,5,6; m_tlast=0; cw_count=0.
- Full codeword: 19 words (word k slice s = k*6+s) with m_tready=1 and in_valid every 6 cycles → 114 slices in order; m_tlast only on slice value 113; cw_count=1; overflow=0.
- Backpressure: m_tready toggles 1,0,1,0 during a word → each slice held stable while m_tready=0; no slice lost or duplicated.
- Overflow: m_tready=0; in_valid on 3 consecutive cycles with words A,B,C → A and B buffered, C dropped, overflow=1. Raising m_tready then yields A's 6 slices followed by B's 6 slices.
- Simultaneous write and final pop: occupancy=2, in_valid coincides with the pop of slice 5 → word accepted, overflow stays 0, occupancy stays 2.
- Async reset mid-word: rst low after 3 slices of word 4 → all outputs 0 immediately. After release, the next word is emitted from slice 0, and m_tlast appears after 19 further words.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC codeword geometry and types used by qc_encoder, the serializer and their benches.
package ldpc_pkg;

   localparam int CW_IN_W    = 162;
   localparam int CW_SLICE_W = 27;
   localparam int CW_WORDS   = 19;
   localparam int CW_SLICES  = CW_IN_W / CW_SLICE_W;

   typedef logic [CW_IN_W-1:0]    cw_word_t;
   typedef logic [CW_SLICE_W-1:0] cw_slice_t;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_SEND = 1'b1
   } rd_state_e;

   // Word-buffer occupancy after one cycle of optional write and optional word retire.
   function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                           input logic       wr,
                                           input logic       rd);
      logic [1:0] res;
      case ({wr, rd})
         2'b10:   res = occ + 2'd1;
         2'b01:   res = occ - 2'd1;
         default: res = occ;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ldpc_cw_serializer_pingpong_buf.sv
// Two-entry ping-pong word store: write pointer, read pointer and occupancy.
// Storage itself is not reset; only the bookkeeping is.
module cw_pingpong_buf
   import ldpc_pkg::*;
#(
   parameter int W = CW_IN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         pop_word_i,
   output logic         full_o,
   output logic [1:0]   occ_o,
   output logic [W-1:0] rd_word_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   occ_q, occ_d;

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_i) begin
         wr_ptr_d = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_word_i) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      occ_d = occ_next(occ_q, wr_en_i, pop_word_i);
   end

   // Bookkeeping registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Word storage.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign full_o    = (occ_q == 2'd2);
   assign occ_o     = occ_q;
   assign rd_word_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/ldpc_cw_serializer.sv
// Serialises qc_encoder words into OUT_W-bit stream slices, LSB slice first,
// with codeword framing on m_tlast, a codeword counter and a sticky overrun flag.
module ldpc_cw_serializer
   import ldpc_pkg::*;
#(
   parameter int IN_W         = CW_IN_W,
   parameter int OUT_W        = CW_SLICE_W,
   parameter int WORDS_PER_CW = CW_WORDS,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic [OUT_W-1:0] m_tdata,
   output logic             m_tlast,
   output logic             overflow,
   output logic [CNT_W-1:0] cw_count
);

   localparam int SLICES = IN_W / OUT_W;
   localparam int SL_W   = $clog2(SLICES);
   localparam int WD_W   = $clog2(WORDS_PER_CW);
   localparam logic [SL_W-1:0] SLICE_LAST = SL_W'(SLICES - 1);
   localparam logic [WD_W-1:0] WORD_LAST  = WD_W'(WORDS_PER_CW - 1);

   rd_state_e        state_q, state_d;
   logic [SL_W-1:0]  slice_idx_q, slice_idx_d;
   logic [WD_W-1:0]  word_idx_q, word_idx_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cw_count_q, cw_count_d;

   logic             pop_s, word_done_pop_s, wr_en_s, full_s;
   logic [1:0]       occ_s;
   logic [IN_W-1:0]  rd_word_s;
   logic [OUT_W-1:0] slices_s [SLICES];

   // A word arriving while both entries are busy is only accepted if the
   // front word retires in the same cycle; otherwise it is lost.
   assign pop_s           = m_tvalid && m_tready;
   assign word_done_pop_s = pop_s && (slice_idx_q == SLICE_LAST);
   assign wr_en_s         = in_valid && (!full_s || word_done_pop_s);

   cw_pingpong_buf #(.W(IN_W)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en_s),
      .wr_data_i  (in_data),
      .pop_word_i (word_done_pop_s),
      .full_o     (full_s),
      .occ_o      (occ_s),
      .rd_word_o  (rd_word_s)
   );

   for (genvar g = 0; g < SLICES; g++) begin : g_slice
      assign slices_s[g] = rd_word_s[g*OUT_W +: OUT_W];
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Read FSM next state: leave SEND only when the last buffered word retires unreplaced.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE: begin
            if (occ_s != 2'd0) begin
               state_d = RD_SEND;
            end else begin
               state_d = RD_IDLE;
            end
         end
         RD_SEND: begin
            if (word_done_pop_s && (occ_s == 2'd1) && !wr_en_s) begin
               state_d = RD_IDLE;
            end else begin
               state_d = RD_SEND;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Read FSM outputs, mux-derived from registered state so they hold during stalls.
   always_comb begin
      m_tvalid = (state_q == RD_SEND);
      if (m_tvalid) begin
         m_tdata = slices_s[slice_idx_q];
         m_tlast = (slice_idx_q == SLICE_LAST) && (word_idx_q == WORD_LAST);
      end else begin
         m_tdata = {OUT_W{1'b0}};
         m_tlast = 1'b0;
      end
   end

   // Slice/word indices, overrun flag and codeword counter next-state.
   always_comb begin
      slice_idx_d = slice_idx_q;
      word_idx_d  = word_idx_q;
      overflow_d  = overflow_q;
      cw_count_d  = cw_count_q;
      if (word_done_pop_s) begin
         slice_idx_d = {SL_W{1'b0}};
         word_idx_d  = (word_idx_q == WORD_LAST) ? {WD_W{1'b0}} : word_idx_q + WD_W'(1);
      end else if (pop_s) begin
         slice_idx_d = slice_idx_q + SL_W'(1);
      end else begin
         slice_idx_d = slice_idx_q;
      end
      if (in_valid && full_s && !word_done_pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
      if (pop_s && m_tlast) begin
         cw_count_d = cw_count_q + CNT_W'(1);
      end else begin
         cw_count_d = cw_count_q;
      end
   end

   // Index, flag and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slice_idx_q <= {SL_W{1'b0}};
         word_idx_q  <= {WD_W{1'b0}};
         overflow_q  <= 1'b0;
         cw_count_q  <= {CNT_W{1'b0}};
      end else begin
         slice_idx_q <= slice_idx_d;
         word_idx_q  <= word_idx_d;
         overflow_q  <= overflow_d;
         cw_count_q  <= cw_count_d;
      end
   end

   assign overflow = overflow_q;
   assign cw_count = cw_count_q;

endmodule

// File: tb/tb_ldpc_cw_serializer.sv
// Directed self-checking bench for ldpc_cw_serializer.
module tb_ldpc_cw_serializer;
   import ldpc_pkg::*;

   logic      clk = 1'b0;
   logic      rst = 1'b0;
   logic      in_valid = 1'b0;
   cw_word_t  in_data = '0;
   logic      m_tvalid;
   logic      m_tready = 1'b0;
   cw_slice_t m_tdata;
   logic      m_tlast;
   logic      overflow;
   logic [15:0] cw_count;

   int errors = 0;
   int checks = 0;

   ldpc_cw_serializer dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tdata  (m_tdata),
      .m_tlast  (m_tlast),
      .overflow (overflow),
      .cw_count (cw_count)
   );

   always #5 clk = ~clk;

   function automatic cw_word_t mk_word(input int base);
      cw_word_t w;
      for (int s = 0; s < 6; s++) w[s*27 +: 27] = 27'(base + s);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; m_tready = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
      checks++; if (m_tdata !== 27'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      checks++; if (cw_count !== 16'd0) begin errors++; $display("FAIL reset_cw_count got %0d want 0", cw_count); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_word();
      do_reset();
      m_tready = 1'b1;
      in_valid = 1'b1; in_data = mk_word(1);
      tick();
      in_valid = 1'b0;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_latency_early got %b want 0", m_tvalid); end
      tick();
      for (int n = 0; n < 6; n++) begin
         checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid[%0d] got %b want 1", n, m_tvalid); end
         checks++; if (m_tdata !== 27'(n + 1)) begin errors++; $display("FAIL single_tdata[%0d] got %h want %h", n, m_tdata, n + 1); end
         checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL single_tlast[%0d] got %b want 0", n, m_tlast); end
         tick();
      end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_end got %b want 0", m_tvalid); end
      checks++; if (cw_count !== 16'd0) begin errors++; $display("FAIL single_cw_count got %0d want 0", cw_count); end
   endtask

   // Streams one full codeword (word k slice s = k*6+s) from the current state.
   task automatic run_codeword(input string tag);
      int idx = 0;
      int k = 0;
      m_tready = 1'b1;
      for (int cyc = 0; cyc < 400 && idx < 114; cyc++) begin
         if (cyc % 6 == 0 && k < 19) begin
            in_valid = 1'b1; in_data = mk_word(k * 6); k++;
         end else begin
            in_valid = 1'b0;
         end
         if (m_tvalid && m_tready) begin
            checks++; if (m_tdata !== 27'(idx)) begin errors++; $display("FAIL %s_tdata[%0d] got %h want %h", tag, idx, m_tdata, idx); end
            checks++; if (m_tlast !== (idx == 113)) begin errors++; $display("FAIL %s_tlast[%0d] got %b want %b", tag, idx, m_tlast, idx == 113); end
            idx++;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++; if (idx != 114) begin errors++; $display("FAIL %s_timeout got %0d slices want 114", tag, idx); end
      tick();
      checks++; if (cw_count !== 16'd1) begin errors++; $display("FAIL %s_cw_count got %0d want 1", tag, cw_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL %s_overflow got %b want 0", tag, overflow); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL %s_idle got %b want 0", tag, m_tvalid); end
   endtask

   task automatic test_full_codeword();
      do_reset();
      run_codeword("cw");
   endtask

   task automatic test_backpressure();
      int n = 0;
      do_reset();
      in_valid = 1'b1; in_data = mk_word(16);
      tick();
      in_valid = 1'b0;
      tick();
      for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
         m_tready = (cyc % 2 == 0);
         checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid[%0d] got %b want 1", cyc, m_tvalid); end
         checks++; if (m_tdata !== 27'(16 + n)) begin errors++; $display("FAIL bp_tdata[%0d] got %h want %h", cyc, m_tdata, 16 + n); end
         if (m_tvalid && m_tready) n++;
         tick();
      end
      checks++; if (n != 6) begin errors++; $display("FAIL bp_count got %0d want 6", n); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", m_tvalid); end
   endtask

   task automatic test_overflow();
      int n = 0;
      int exp_v;
      do_reset();
      m_tready = 1'b0;
      in_valid = 1'b1; in_data = mk_word(256); tick();
      in_data = mk_word(512); tick();
      in_data = mk_word(768); tick();
      in_valid = 1'b0;
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
      checks++; if (m_tdata !== 27'd256) begin errors++; $display("FAIL ovf_hold got %h want 100", m_tdata); end
      m_tready = 1'b1;
      for (int cyc = 0; cyc < 30 && n < 12; cyc++) begin
         if (m_tvalid && m_tready) begin
            exp_v = (n < 6) ? 256 + n : 512 + n - 6;
            checks++; if (m_tdata !== 27'(exp_v)) begin errors++; $display("FAIL ovf_tdata[%0d] got %h want %h", n, m_tdata, exp_v); end
            n++;
         end
         tick();
      end
      checks++; if (n != 12) begin errors++; $display("FAIL ovf_count got %0d want 12", n); end
      tick();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got %b want 0", m_tvalid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int exp_v;
      do_reset();
      m_tready = 1'b0;
      in_valid = 1'b1; in_data = mk_word(768); tick();
      in_data = mk_word(1024); tick();
      in_valid = 1'b0;
      tick();
      m_tready = 1'b1;
      for (int cyc = 0; cyc < 40 && n < 18; cyc++) begin
         if (m_tvalid && m_tready) begin
            exp_v = 768 + (n / 6) * 256 + (n % 6);
            checks++; if (m_tdata !== 27'(exp_v)) begin errors++; $display("FAIL b2b_tdata[%0d] got %h want %h", n, m_tdata, exp_v); end
            in_valid = (n == 5);
            in_data = mk_word(1280);
            n++;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++; if (n != 18) begin errors++; $display("FAIL b2b_count got %0d want 18", n); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
      tick();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", m_tvalid); end
   endtask

   task automatic test_async_reset();
      int pops = 0;
      int k = 0;
      logic pend;
      do_reset();
      m_tready = 1'b1;
      for (int cyc = 0; cyc < 200 && pops < 27; cyc++) begin
         if (cyc % 6 == 0 && k < 5) begin
            in_valid = 1'b1; in_data = mk_word(k * 6); k++;
         end else begin
            in_valid = 1'b0;
         end
         pend = m_tvalid && m_tready;
         tick();
         if (pend) pops++;
      end
      in_valid = 1'b0;
      checks++; if (m_tdata !== 27'd27) begin errors++; $display("FAIL ar_midword got %h want 1b", m_tdata); end
      #2 rst = 1'b0;
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ar_tvalid got %b want 0", m_tvalid); end
      checks++; if (m_tdata !== 27'd0) begin errors++; $display("FAIL ar_tdata got %h want 0", m_tdata); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL ar_tlast got %b want 0", m_tlast); end
      tick();
      rst = 1'b1;
      tick();
      run_codeword("ar");
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_codeword();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
